// File: rtl/alu_sched_if.sv
// Bundles the two request channels, the ALU pin group and the tagged response
// channel of alu_sched. The slave modport is the scheduler; master is its environment.
interface alu_sched_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_A;
  logic [WIDTH-1:0] req0_B;
  logic [3:0]       req0_sel;
  logic             req0_Cin;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_A;
  logic [WIDTH-1:0] req1_B;
  logic [3:0]       req1_sel;
  logic             req1_Cin;

  logic [WIDTH-1:0] alu_A;
  logic [WIDTH-1:0] alu_B;
  logic [3:0]       alu_sel;
  logic             alu_Cin;
  logic [WIDTH-1:0] alu_Y;
  logic             alu_Cout;
  logic             alu_Negative;
  logic             alu_Zero;
  logic             alu_Overflow;

  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH-1:0] resp_Y;
  logic             resp_Cout;
  logic             resp_Negative;
  logic             resp_Zero;
  logic             resp_Overflow;
  logic             resp_err;

  modport slave (
    input  req0_valid, req0_A, req0_B, req0_sel, req0_Cin,
    output req0_ready,
    input  req1_valid, req1_A, req1_B, req1_sel, req1_Cin,
    output req1_ready,
    output alu_A, alu_B, alu_sel, alu_Cin,
    input  alu_Y, alu_Cout, alu_Negative, alu_Zero, alu_Overflow,
    output resp_valid, resp_id, resp_Y, resp_Cout, resp_Negative, resp_Zero,
           resp_Overflow, resp_err,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_A, req0_B, req0_sel, req0_Cin,
    input  req0_ready,
    output req1_valid, req1_A, req1_B, req1_sel, req1_Cin,
    input  req1_ready,
    input  alu_A, alu_B, alu_sel, alu_Cin,
    output alu_Y, alu_Cout, alu_Negative, alu_Zero, alu_Overflow,
    input  resp_valid, resp_id, resp_Y, resp_Cout, resp_Negative, resp_Zero,
           resp_Overflow, resp_err,
    output resp_ready
  );
endinterface

// File: rtl/alu_sched.sv
// Shares one combinational ALU between two requesters: arbitrate, execute one cycle, respond.
// Define ALU_SCHED_RR_EN for round-robin contention; otherwise req0 has fixed priority.
module alu_sched #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, y_reg;
  logic [3:0]       sel_reg;
  logic             cin_reg, id_reg;
  logic             cout_reg, neg_reg, zero_reg, ovf_reg, err_reg;
  logic             grant0, grant1, accept, illegal;
`ifdef ALU_SCHED_RR_EN
  logic             last_grant_reg;
`endif

  assign illegal = (sel_reg > 4'd5);
  assign accept  = grant0 | grant1;

  always_comb begin
    state_next = state_reg;
    grant0     = 1'b0;
    grant1     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_SCHED_RR_EN
          grant0 = last_grant_reg;
          grant1 = ~last_grant_reg;
`else
          grant0 = 1'b1;
`endif
        end else begin
          grant0 = bus.req0_valid;
          grant1 = bus.req1_valid;
        end
        if (grant0 || grant1) state_next = EXEC;
      end
      EXEC:    state_next = RESP;
      RESP:    if (bus.resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Operands are only latched on a handshake, so the ALU pins stay quiet otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sel_reg <= '0;
      cin_reg <= 1'b0;
      id_reg  <= 1'b0;
    end else if (accept) begin
      a_reg   <= grant1 ? bus.req1_A   : bus.req0_A;
      b_reg   <= grant1 ? bus.req1_B   : bus.req0_B;
      sel_reg <= grant1 ? bus.req1_sel : bus.req0_sel;
      cin_reg <= grant1 ? bus.req1_Cin : bus.req0_Cin;
      id_reg  <= grant1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_reg    <= '0;
      cout_reg <= 1'b0;
      neg_reg  <= 1'b0;
      zero_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      err_reg  <= 1'b0;
    end else if (state_reg == EXEC) begin
      if (illegal) begin
        y_reg    <= '0;
        cout_reg <= 1'b0;
        neg_reg  <= 1'b0;
        zero_reg <= 1'b0;
        ovf_reg  <= 1'b0;
        err_reg  <= 1'b1;
      end else begin
        y_reg    <= bus.alu_Y;
        cout_reg <= bus.alu_Cout;
        neg_reg  <= bus.alu_Negative;
        zero_reg <= bus.alu_Zero;
        ovf_reg  <= bus.alu_Overflow;
        err_reg  <= 1'b0;
      end
    end
  end

`ifdef ALU_SCHED_RR_EN
  // Starts at 1 so req0 wins the first contention after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant_reg <= 1'b1;
    else if (accept) last_grant_reg <= grant1;
  end
`endif

  assign bus.req0_ready    = grant0;
  assign bus.req1_ready    = grant1;
  assign bus.alu_A         = a_reg;
  assign bus.alu_B         = b_reg;
  assign bus.alu_sel       = sel_reg;
  assign bus.alu_Cin       = cin_reg;
  assign bus.resp_valid    = (state_reg == RESP);
  assign bus.resp_id       = id_reg;
  assign bus.resp_Y        = y_reg;
  assign bus.resp_Cout     = cout_reg;
  assign bus.resp_Negative = neg_reg;
  assign bus.resp_Zero     = zero_reg;
  assign bus.resp_Overflow = ovf_reg;
  assign bus.resp_err      = err_reg;
endmodule

// File: tb/tb_alu_sched.sv
// Bench for alu_sched: directed scenarios plus randomized traffic checked against a
// transaction-level model (one outstanding op, arbitration rule, one-cycle execute).
module tb_alu_sched;
  localparam int WIDTH = 32;

  typedef struct packed {
    logic             err;
    logic             cout;
    logic             neg;
    logic             zero;
    logic             ovf;
    logic [WIDTH-1:0] y;
  } res_t;

  typedef struct packed {
    logic id;
    res_t r;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sched_if #(.WIDTH(WIDTH)) bus ();

  alu_sched #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Stand-in ALU; illegal codes produce garbage so a missing error path is visible.
  function automatic res_t alu_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic [3:0] sel, input logic cin);
    res_t         r;
    logic [WIDTH:0] s;
    r = '0;
    s = '0;
    case (sel)
      4'd0: r.y = a & b;
      4'd1: r.y = a | b;
      4'd2: begin
        s      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        r.y    = s[WIDTH-1:0];
        r.cout = s[WIDTH];
        r.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (r.y[WIDTH-1] != a[WIDTH-1]);
      end
      4'd3: begin
        s      = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};
        r.y    = s[WIDTH-1:0];
        r.cout = s[WIDTH];
        r.ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (r.y[WIDTH-1] != a[WIDTH-1]);
      end
      4'd4: r.y = a ^ b;
      4'd5: r.y = ~a;
      default: begin
        r.y    = 32'hDEAD_BEEF;
        r.cout = 1'b1;
        r.ovf  = 1'b1;
      end
    endcase
    r.neg  = r.y[WIDTH-1];
    r.zero = (r.y == '0);
    return r;
  endfunction

  // What the scheduler should report for an operation.
  function automatic res_t expect_fn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic [3:0] sel, input logic cin);
    res_t r;
    if (sel > 4'd5) begin
      r     = '0;
      r.err = 1'b1;
    end else begin
      r = alu_fn(a, b, sel, cin);
    end
    return r;
  endfunction

  res_t alu_r;
  always_comb alu_r = alu_fn(bus.alu_A, bus.alu_B, bus.alu_sel, bus.alu_Cin);
  assign bus.alu_Y        = alu_r.y;
  assign bus.alu_Cout     = alu_r.cout;
  assign bus.alu_Negative = alu_r.neg;
  assign bus.alu_Zero     = alu_r.zero;
  assign bus.alu_Overflow = alu_r.ovf;

  // Transaction model: at most one op outstanding from acceptance until its response is taken.
  exp_t exp_q[$];
  int   age       = 0;
  logic last_id_m = 1'b1;
  int   id_log[$];

  always @(negedge clk) begin
    logic e0, e1;
    exp_t x;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!rst_n) begin
      exp_q.delete();
      age       = 0;
      last_id_m = 1'b1;
    end else begin
      if (exp_q.size() != 0) age++;
      if (exp_q.size() == 0) begin
        if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_SCHED_RR_EN
          if (last_id_m) e0 = 1'b1;
          else           e1 = 1'b1;
`else
          e0 = 1'b1;
`endif
        end else begin
          e0 = bus.req0_valid;
          e1 = bus.req1_valid;
        end
      end
      check("req0_ready", 64'(bus.req0_ready), 64'(e0));
      check("req1_ready", 64'(bus.req1_ready), 64'(e1));
      check("resp_valid", 64'(bus.resp_valid), 64'(exp_q.size() != 0 && age >= 2));
      if (bus.resp_valid && exp_q.size() != 0 && age >= 2) begin
        x = exp_q[0];
        check("resp_id", 64'(bus.resp_id), 64'(x.id));
        check("resp_Y", 64'(bus.resp_Y), 64'(x.r.y));
        check("resp_flags",
              64'({bus.resp_Cout, bus.resp_Negative, bus.resp_Zero, bus.resp_Overflow}),
              64'({x.r.cout, x.r.neg, x.r.zero, x.r.ovf}));
        check("resp_err", 64'(bus.resp_err), 64'(x.r.err));
        if (bus.resp_ready) begin
          id_log.push_back(int'(x.id));
          void'(exp_q.pop_front());
        end
      end
      if (e0 || e1) begin
        x.id = e1;
        x.r  = e1 ? expect_fn(bus.req1_A, bus.req1_B, bus.req1_sel, bus.req1_Cin)
                  : expect_fn(bus.req0_A, bus.req0_B, bus.req0_sel, bus.req0_Cin);
        exp_q.push_back(x);
        age       = 0;
        last_id_m = e1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_A = '0; bus.req0_B = '0; bus.req0_sel = '0; bus.req0_Cin = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_A = '0; bus.req1_B = '0; bus.req1_sel = '0; bus.req1_Cin = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] a, b;
    res_t             r;
    int               n;
    int               exp_ids[4];

    idle_inputs();
    bus.resp_ready = 1'b0;
    rst_n          = 1'b0;
    repeat (3) tick();
    check("rst_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'(0));
    check("rst_resp", 64'({bus.resp_valid, bus.resp_id, bus.resp_Cout, bus.resp_Negative,
                           bus.resp_Zero, bus.resp_Overflow, bus.resp_err}), 64'(0));
    check("rst_resp_Y", 64'(bus.resp_Y), 64'(0));
    check("rst_alu", 64'({bus.alu_A, bus.alu_sel, bus.alu_Cin}), 64'(0));
    check("rst_alu_B", 64'(bus.alu_B), 64'(0));
    rst_n = 1'b1;
    tick();

    // Single AND from req0: response at the second edge after the handshake.
    bus.req0_A = 32'h0000_00F0; bus.req0_B = 32'h0000_00FF; bus.req0_sel = 4'd0;
    bus.req0_valid = 1'b1; bus.resp_ready = 1'b1;
    #1;
    check("single_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'(2'b10));
    tick();
    bus.req0_valid = 1'b0;
    check("single_exec_valid", 64'(bus.resp_valid), 64'(0));
    check("single_alu_A", 64'(bus.alu_A), 64'(32'h0000_00F0));
    tick();
    check("single_valid", 64'(bus.resp_valid), 64'(1));
    check("single_Y", 64'(bus.resp_Y), 64'(32'h0000_00F0));
    check("single_id_err", 64'({bus.resp_id, bus.resp_err}), 64'(0));
    tick();
    check("single_done", 64'(bus.resp_valid), 64'(0));

    // Illegal op code from req1.
    bus.req1_A = 32'h1234_5678; bus.req1_B = 32'h8000_0001; bus.req1_sel = 4'b1010;
    bus.req1_valid = 1'b1;
    tick();
    bus.req1_valid = 1'b0;
    tick();
    check("illegal_err", 64'({bus.resp_valid, bus.resp_id, bus.resp_err}), 64'(3'b111));
    check("illegal_Y", 64'(bus.resp_Y), 64'(0));
    check("illegal_flags", 64'({bus.resp_Cout, bus.resp_Negative, bus.resp_Zero,
                                bus.resp_Overflow}), 64'(0));
    tick();

    // Backpressure: RESP held 5 cycles while both requesters wait.
    bus.resp_ready = 1'b0;
    a = 32'h7FFF_FFFF; b = 32'h0000_0001;
    bus.req0_A = a; bus.req0_B = b; bus.req0_sel = 4'd2; bus.req0_Cin = 1'b0;
    bus.req0_valid = 1'b1;
    r = expect_fn(a, b, 4'd2, 1'b0);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", 64'(bus.resp_valid), 64'(1));
      check("bp_Y", 64'(bus.resp_Y), 64'(r.y));
      check("bp_flags", 64'({bus.resp_Cout, bus.resp_Negative, bus.resp_Zero,
                             bus.resp_Overflow}), 64'({r.cout, r.neg, r.zero, r.ovf}));
      check("bp_ready", 64'({bus.req0_ready, bus.req1_ready}), 64'(0));
    end
    bus.resp_ready = 1'b1;
    tick();
    check("bp_release", 64'(bus.resp_valid), 64'(0));
    check("bp_idle_grant", 64'(bus.req0_ready | bus.req1_ready), 64'(1));
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (2) tick();

    // Reset during EXEC aborts the operation.
    bus.req0_A = 32'hFFFF_0000; bus.req0_B = 32'h0F0F_0F0F; bus.req0_sel = 4'd1;
    bus.req0_valid = 1'b1;
    tick();
    bus.req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_alu", 64'({bus.alu_A, bus.alu_sel, bus.alu_Cin}), 64'(0));
    check("midrst_resp", 64'({bus.resp_valid, bus.resp_err, bus.req0_ready, bus.req1_ready}), 64'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_no_resp", 64'(bus.resp_valid), 64'(0));
    end

    // Contention straight after reset, both valid continuously.
    id_log.delete();
    bus.req0_A = 32'h0000_0003; bus.req0_B = 32'h0000_0005; bus.req0_sel = 4'd4;
    bus.req1_A = 32'h0000_0010; bus.req1_B = 32'h0000_0020; bus.req1_sel = 4'd2;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.resp_ready = 1'b1;
    n = 0;
    while (id_log.size() < 4 && n < 40) begin
      tick();
      n++;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    check("cont_count", 64'(id_log.size()), 64'(4));
`ifdef ALU_SCHED_RR_EN
    exp_ids = '{0, 1, 0, 1};
`else
    exp_ids = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) begin
      if (i < id_log.size()) check($sformatf("cont_id%0d", i), 64'(id_log[i]), 64'(exp_ids[i]));
      else check($sformatf("cont_id%0d_missing", i), 64'(i), 64'(id_log.size()));
    end
    repeat (2) tick();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bus.req0_valid = ($urandom_range(0, 2) != 0);
      bus.req0_A     = $urandom();
      bus.req0_B     = $urandom();
      bus.req0_sel   = 4'($urandom_range(0, 7));
      bus.req0_Cin   = 1'($urandom_range(0, 1));
      bus.req1_valid = ($urandom_range(0, 2) != 0);
      bus.req1_A     = $urandom();
      bus.req1_B     = $urandom();
      bus.req1_sel   = 4'($urandom_range(0, 7));
      bus.req1_Cin   = 1'($urandom_range(0, 1));
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    idle_inputs();
    bus.resp_ready = 1'b1;
    repeat (5) tick();
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_sched.md
# alu_sched

Two-port scheduler that shares one combinational 32-bit ALU instance between two requesters. It arbitrates operation requests, registers the operands, and drives them into the ALU for one execute cycle. It then captures the result and flags and returns them on a single tagged response channel with a valid/ready handshake. It sits between the lab's operand sources and the ALU datapath, owning all ALU input pins.

## Interface
Parameters:
- WIDTH, 32, operand/result width; matches the ALU datapath.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester n presents an operation.
- req0_ready / req1_ready  out  1  scheduler accepts requester n this cycle.
- req0_A, req0_B / req1_A, req1_B  in  WIDTH  operands.
- req0_sel / req1_sel  in  4  ALU op code; legal values are 4'b0000–4'b0101.
- req0_Cin / req1_Cin  in  1  carry-in.
- alu_A, alu_B  out  WIDTH  operands driven into the ALU.
- alu_sel  out  4  op code driven into the ALU.
- alu_Cin  out  1  carry-in driven into the ALU.
- alu_Y  in  WIDTH  ALU result.
- alu_Cout, alu_Negative, alu_Zero, alu_Overflow  in  1  ALU flags.
- resp_valid  out  1  response held stable.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  1  index of the requester that issued the operation.
- resp_Y  out  WIDTH  registered result.
- resp_Cout, resp_Negative, resp_Zero, resp_Overflow  out  1  registered flags.
- resp_err  out  1  op code was illegal; the ALU was not used.

## Operation
The FSM has three states: IDLE, EXEC and RESP.

IDLE:
- Selects a winner among the asserted reqN_valid.
- Asserts reqN_ready combinationally for the winner only.
- On the handshake, latches A, B, sel, Cin and id, then moves to EXEC.
- With no valid request, stays in IDLE and both readys stay 0.

Arbitration:
- One requester valid: that requester wins.
- Both valid: the requester not granted last wins (round-robin).
- last_grant resets to 1, so req0 wins the first contention.
- last_grant updates only on a handshake.

EXEC:
- alu_* pins are driven from the latched registers.
- At the end of the cycle, alu_Y and the four flags are captured into the resp_* registers, and the FSM moves to RESP.
- If the latched sel > 4'b0101: resp_Y = 0, all four flags = 0, resp_err = 1.
- Otherwise resp_err = 0.

RESP:
- resp_valid = 1; all resp_* are held stable.
- On resp_valid & resp_ready, moves to IDLE.
- Both reqN_ready are 0 throughout EXEC and RESP; no request is dropped, and valids are simply not acknowledged.

Outside EXEC, alu_* keep showing the latched registers. This removes spurious toggles and creates no functional dependency.

Results pass through width-exact; the scheduler does no arithmetic on them.

## Timing
- Reset values while rst_n = 0, applied immediately (async): state = IDLE, req0_ready = req1_ready = 0, resp_valid = 0, resp_id = 0, resp_Y = 0, all resp flags = 0, resp_err = 0, alu_A = alu_B = 0, alu_sel = 0, alu_Cin = 0, last_grant = 1.
- Reset mid-operation aborts the in-flight operation with no response.
- Handshake at edge t → EXEC during cycle t..t+1 → resp_valid high from edge t+1. That is one cycle from acceptance to response valid.
- Minimum issue interval is 3 cycles (IDLE, EXEC, RESP) with resp_ready tied to 1.
- resp_ready low holds RESP indefinitely with outputs unchanged.
- A valid arriving during RESP is accepted no earlier than the IDLE cycle that follows.
- reqN_ready depends on state and the valids only, never on resp_ready.

## Configuration
- ALU_SCHED_RR_EN defined: round-robin arbitration as described.
- ALU_SCHED_RR_EN undefined: fixed priority, where req0 always wins contention. last_grant is not implemented and req1 can starve.

## Test plan
- Reset: rst_n low mid-EXEC → all outputs at reset values immediately; no response after release.
- Single op: req0 A = 32'h0000_00F0, B = 32'h0000_00FF, sel = 4'b0000 → resp_id = 0, resp_Y equals the ALU model's AND result, resp_err = 0, resp_valid at the second edge after the handshake.
- Contention with ALU_SCHED_RR_EN: both valid continuously for 4 ops, resp_ready = 1 → resp_id sequence 0, 1, 0, 1; each ready pulse is exactly one cycle.
- Contention without the macro: same stimulus → resp_id 0, 0, 0, 0.
- Backpressure: resp_ready = 0 for 5 cycles in RESP → resp_* stable, both readys 0; release → IDLE next cycle.
- Illegal op: sel = 4'b1010 → resp_err = 1, resp_Y = 0, all flags 0.
